dac_sample_feeder: RTL
======================

Name: dac_sample_feeder

Overview:
- Upstream stage of ds_DAC: buffers 8-bit samples from a producer through a valid/ready handshake.
- Releases one sample per programmable sample-rate strobe and presents it as the held `value` word driving ds_DAC.
- Contains a small FIFO, a sample-rate divider and a prime/run state machine, plus underrun reporting.

Parameters:
- WIDTH, 8, sample width; matches ds_DAC value width.
- DEPTH, 4, FIFO depth in samples; power of 2, minimum 2.
- DIV_W, 16, width of the divisor input and the divider counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- en  in  1  run enable for playback.
- divisor  in  DIV_W  clk cycles per sample; 0 and 1 both mean every cycle.
- in_data  in  WIDTH  sample from the producer.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready at a clk edge.
- value  out  WIDTH  registered sample to ds_DAC.value.
- strobe  out  1  one-cycle pulse, high in the cycle value is updated (or the update was missed).
- underflow  out  1  one-cycle pulse: strobe fired with the FIFO empty.
- underrun_cnt  out  8  saturating count of underflow events.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (clr high, async):
  - value = 2^(WIDTH-1) (midscale, 128 at WIDTH=8).
  - strobe, underflow, underrun_cnt, level and divider count = 0.
  - FSM = IDLE.
  - in_ready = 0 while clr is high; in_ready = !full after release.
- FIFO:
  - Circular buffer with registered level.
  - in_ready derives from registered level only, so no write is accepted at full even if a pop occurs in the same cycle.
  - A write becomes visible in level on the next cycle.
  - Simultaneous push and pop when not empty and not full: level unchanged.
  - Pop at empty has no fall-through: the underflow path is taken and the pushed word is stored.
- Divider:
  - Active only in RUN; in any other state div_cnt = 0.
  - Effective divisor D = max(divisor, 1).
  - When div_cnt >= D-1: div_cnt <= 0 and strobe is registered high for one cycle; otherwise div_cnt increments.
  - A divisor change takes effect on the next comparison; shrinking below the current div_cnt fires at once.
  - Strobe period is exactly D cycles.
- FSM:
  - IDLE -> PRIME when en = 1.
  - PRIME -> RUN when level >= DEPTH/2 and en = 1.
  - PRIME -> IDLE when en = 0.
  - RUN -> IDLE when en = 0.
  - An empty FIFO in RUN never leaves RUN.
- Strobe action (same edge as strobe goes high):
  - If level > 0: pop the FIFO head into value.
  - Else: hold value, pulse underflow, increment underrun_cnt; it saturates at 255 and is cleared only by clr.
- First strobe in RUN occurs D cycles after entering RUN, not immediately.
- In IDLE and PRIME:
  - value is held at its last value; it returns to midscale only on clr.
  - Writes are still accepted.
  - No strobes are generated.
- clr mid-operation discards all FIFO contents and any pending strobe immediately.
- Outputs strobe, underflow and value are all registered; no combinational path from in_* to outputs except in_ready (from the registered level).

Decomposition:
- Shared package dac_pkg holds:
  - the state enum (IDLE, PRIME, RUN);
  - MIDSCALE constant;
  - default WIDTH, DEPTH and DIV_W constants reused by ds_DAC benches.
- Natural sub-module: sample_fifo (WIDTH, DEPTH) with push/pop/level, instantiated once.
- Divider and FSM stay in the top level.

Test Plan:
- Reset value: clr pulse, en = 0 -> value = 128, in_ready = 0 during clr and 1 after, level = 0, no strobe for 1000 cycles.
- Nominal playback:
  - Stimulus: divisor = 4; push 10, 20 then en = 1; then push 30, 40.
  - Required: RUN entered once level >= 2; strobe every 4 cycles; value sequence 10, 20, 30, 40; underflow = 0.
- Full FIFO: push 4 samples with en = 0 -> in_ready = 0 and level = 4; a 5th in_valid is not accepted; after one strobe in RUN, in_ready returns to 1.
- Underflow:
  - Stimulus: divisor = 2, two samples, en = 1, no further pushes.
  - Required: after 2 pops, the next strobes hold value at the last sample, pulse underflow and count up; after 300 underflows underrun_cnt = 255.
- Divisor edge cases:
  - divisor = 0 and divisor = 1 -> strobe every cycle, with continuous pushes each cycle keeping the FIFO non-empty.
  - Change divisor 8 -> 3 while div_cnt = 5 -> strobe on the next cycle, then period 3.
- Reset and disable mid-operation:
  - clr asserted mid-RUN with level = 3 -> level = 0 and value = 128 asynchronously; state IDLE.
  - en dropped mid-RUN -> strobes stop, value held, re-prime required before the next strobe.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and defaults for the ds_DAC sample feed path.
package dac_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } feed_state_e;

    function automatic int midscale(input int w);
        return 1 << (w - 1);
    endfunction

    localparam logic [DEF_WIDTH-1:0] MIDSCALE = DEF_WIDTH'(midscale(DEF_WIDTH));

endpackage

// File: rtl/dac_sample_feeder_fifo.sv
// Circular sample buffer with registered occupancy for the DAC feeder.
module sample_fifo
    import dac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers producer samples and releases one per rate strobe to ds_DAC.
module dac_sample_feeder
    import dac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     en,
    input  logic [DIV_W-1:0]         divisor,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         value,
    output logic                     strobe,
    output logic                     underflow,
    output logic [7:0]               underrun_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int               LW   = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0] MID  = WIDTH'(midscale(WIDTH));
    localparam logic [LW-1:0]    HALF = LW'(DEPTH / 2);

    feed_state_e      state_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_eff;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] head;
    logic [7:0]       underrun_q;
    logic             strobe_q;
    logic             underflow_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             fire;

    assign div_eff  = (divisor == '0) ? DIV_W'(1) : divisor;
    assign fire     = (state_q == RUN) && en
                   && (div_cnt_q >= div_eff - DIV_W'(1));
    assign pop      = fire && !empty;
    assign in_ready = !clr && !full;
    assign push     = in_valid && in_ready;

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (in_data),
        .rd_data_o (head),
        .level_o   (level),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
            underrun_q  <= '0;
            value_q     <= MID;
        end else begin
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    div_cnt_q <= '0;
                    if (en) begin
                        state_q <= PRIME;
                    end
                end
                PRIME: begin
                    div_cnt_q <= '0;
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (level >= HALF) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_q   <= IDLE;
                        div_cnt_q <= '0;
                    end else if (fire) begin
                        div_cnt_q <= '0;
                        strobe_q  <= 1'b1;
                        // An empty buffer holds the output and stays in RUN.
                        if (!empty) begin
                            value_q <= head;
                        end else begin
                            underflow_q <= 1'b1;
                            if (underrun_q != 8'hFF) begin
                                underrun_q <= underrun_q + 8'd1;
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    div_cnt_q <= '0;
                end
            endcase
        end
    end

    assign value        = value_q;
    assign strobe       = strobe_q;
    assign underflow    = underflow_q;
    assign underrun_cnt = underrun_q;

endmodule
